spi_slave_counter_rx: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave_counter_rx.sv | 119 +++++++++++
 tb/tb_spi_slave_counter_rx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and receive-state encoding for the SPI counter-frame slave.
package spi_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_HIGH = 2'd1,
        RX_LOW  = 2'd2,
        WAIT_SS = 2'd3
    } rx_state_e;

    localparam int FRAME_BITS = 16;
    localparam int BYTE_BITS  = 8;
    localparam logic [7:0] MISO_STATUS = 8'h5A;
endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses for an asynchronous input.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   fill;

    assign q = chain[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
            fill  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= q;
            fill <= {fill[STAGES-1:0], 1'b1};
            // Edges are only reported once both q and prev hold real samples,
            // so a line already sitting at the non-idle level after reset is not an edge.
            rise <= fill[STAGES] & q & ~prev;
            fall <= fill[STAGES] & ~q & prev;
        end
    end
endmodule

// File: rtl/spi_slave_counter_rx.sv
// SPI mode-0 slave rebuilding a 14-bit counter from a 2-byte frame; MISO returns frame count and status.
module spi_slave_counter_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic [DATA_W-1:0] o_counter,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic              o_busy
);
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;

    rx_state_e              state;
    logic [4:0]             bit_cnt;
    logic [FRAME_BITS-1:0]  shift, shift_nxt, tx;
    logic                   extra;
    logic [7:0]             frame_cnt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .d(ss), .q(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) mosi_chain[i] <= mosi_chain[i-1];
        end
    end

    assign mosi_s    = mosi_chain[SYNC_STAGES-1];
    assign shift_nxt = {shift[FRAME_BITS-2:0], mosi_s};
    assign miso      = ~ss_lvl & tx[FRAME_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            extra       <= 1'b0;
            frame_cnt   <= '0;
            o_counter   <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= RX_HIGH;
                        bit_cnt <= '0;
                        shift   <= '0;
                        extra   <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                RX_HIGH, RX_LOW: begin
                    if (ss_rise) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shift   <= shift_nxt;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(BYTE_BITS - 1)) state <= RX_LOW;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            state <= WAIT_SS;
                            if (shift_nxt[FRAME_BITS-1:DATA_W] == '0) begin
                                o_counter <= shift_nxt[DATA_W-1:0];
                                o_valid   <= 1'b1;
                                frame_cnt <= frame_cnt + 8'd1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_SS: begin
                    // Bit count stays at 16; overrun is only remembered and reported at ss rise.
                    if (sclk_rise) extra <= 1'b1;
                    if (ss_rise) begin
                        state       <= IDLE;
                        o_busy      <= 1'b0;
                        o_frame_err <= extra;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx <= '0;
        end else if (ss_fall && state == IDLE) begin
            tx <= {frame_cnt, MISO_STATUS};
        end else if (sclk_fall && !sclk_lvl && state != IDLE) begin
            tx <= {tx[FRAME_BITS-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// Directed bench for spi_slave_counter_rx: frames, errors, abort, overrun and mid-frame reset.
module tb_spi_slave_counter_rx;
    logic        clk = 1'b0;
    logic        reset, sclk, mosi, ss;
    logic        miso;
    logic [13:0] o_counter;
    logic        o_valid, o_frame_err, o_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0;
    int valid_cyc = 0, err_cyc = 0, rise_cyc = 0;
    int v0, e0;
    logic [15:0] mword;
    logic        busy_mid;

    spi_slave_counter_rx dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
        .o_counter(o_counter), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (o_valid)     begin valid_cnt++; valid_cyc = cyc; end
            if (o_frame_err) begin err_cnt++;   err_cyc   = cyc; end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_bit(input logic b, inout logic [15:0] w, input int idx);
        mosi = b;
        repeat (5) @(negedge clk);
        if (idx < 16) w[15-idx] = miso;
        sclk = 1'b1;
        rise_cyc = cyc;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits, input int gap,
                              output logic [15:0] w, output logic bmid);
        w = '0;
        bmid = 1'b0;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk_bit((i < 16) ? data[15-i] : 1'b0, w, i);
            if (i == 7) bmid = o_busy;
        end
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_counter", 32'(o_counter), 32'h0);
        check("rst_valid",   32'(o_valid), 32'h0);
        check("rst_err",     32'(o_frame_err), 32'h0);
        check("rst_busy",    32'(o_busy), 32'h0);
        check("rst_miso",    32'(miso), 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Frame 0x0ABC
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(16'h0ABC, 16, 10, mword, busy_mid);
        check("f1_counter", 32'(o_counter), 32'h0ABC);
        check("f1_valid_n", 32'(valid_cnt - v0), 32'd1);
        check("f1_err_n",   32'(err_cnt - e0), 32'd0);
        check("f1_latency", 32'(valid_cyc - rise_cyc), 32'd4);
        check("f1_miso",    32'(mword), 32'h005A);
        check("f1_busy_mid", 32'(busy_mid), 32'h1);
        check("f1_busy_end", 32'(o_busy), 32'h0);

        // Back-to-back 0x3FFF then 0x0000 from a fresh frame count
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        v0 = valid_cnt;
        send_frame(16'h3FFF, 16, 2, mword, busy_mid);
        check("f2a_counter", 32'(o_counter), 32'h3FFF);
        check("f2a_miso",    32'(mword), 32'h005A);
        send_frame(16'h0000, 16, 10, mword, busy_mid);
        check("f2b_counter", 32'(o_counter), 32'h0000);
        check("f2_valid_n",  32'(valid_cnt - v0), 32'd2);
        check("f2b_miso",    32'(mword), 32'h015A);

        // 17 pulses, valid 0x0123 latched then overrun error at ss rise
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(16'h0123, 17, 10, mword, busy_mid);
        check("ovr_counter", 32'(o_counter), 32'h0123);
        check("ovr_valid_n", 32'(valid_cnt - v0), 32'd1);
        check("ovr_err_n",   32'(err_cnt - e0), 32'd1);
        check("ovr_order",   32'(err_cyc > rise_cyc + 5), 32'h1);

        // Padding bits set: high byte 0x4A
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(16'h4A00, 16, 10, mword, busy_mid);
        check("pad_err_n",   32'(err_cnt - e0), 32'd1);
        check("pad_valid_n", 32'(valid_cnt - v0), 32'd0);
        check("pad_counter", 32'(o_counter), 32'h0123);

        // Abort after 9 bits
        e0 = err_cnt;
        send_frame(16'h1234, 9, 10, mword, busy_mid);
        check("abort_err_n",   32'(err_cnt - e0), 32'd1);
        check("abort_counter", 32'(o_counter), 32'h0123);
        check("abort_busy",    32'(o_busy), 32'h0);

        // Reset after 5 bits, then a full frame 0x0055
        e0 = err_cnt;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) sclk_bit(1'b1, mword, i);
        reset = 1'b1;
        ss = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_err_n",   32'(err_cnt - e0), 32'd0);
        check("rstmid_counter", 32'(o_counter), 32'h0);
        send_frame(16'h0055, 16, 10, mword, busy_mid);
        check("rstmid_f_counter", 32'(o_counter), 32'h0055);
        check("rstmid_f_miso",    32'(mword), 32'h005A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
